// File: rtl/gcode_cmd_serializer.sv
// gcode_cmd_serializer
// Queues G-code commands {cmd, x, y} in a small FIFO and serialises each one
// as a frame of WORD_W-bit words: cmd words, then x words, then y words.
// Each field is sent least-significant word first, and the top word of each
// field is zero-padded.
// Optional feature macro: GCODE_CMD_SER_CHECKSUM_EN appends one extra word to
// every frame. That word is the XOR of all the words before it in the frame.
module gcode_cmd_serializer #(
  parameter int CMD_W  = 5,
  parameter int VAL_W  = 14,
  parameter int WORD_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CMD_W-1:0]  i_cmd,
  input  logic [VAL_W-1:0]  i_x_value,
  input  logic [VAL_W-1:0]  i_y_value,
  input  logic              i_ctrl_ready,
  output logic              o_word_valid,
  input  logic              i_word_ready,
  output logic [WORD_W-1:0] o_word_data,
  output logic              o_word_last,
  output logic              o_busy,
  output logic [7:0]        o_frame_cnt
);

  localparam int NC = (CMD_W + WORD_W - 1) / WORD_W;
  localparam int NV = (VAL_W + WORD_W - 1) / WORD_W;
`ifdef GCODE_CMD_SER_CHECKSUM_EN
  localparam int NW = NC + 2 * NV + 1;
`else
  localparam int NW = NC + 2 * NV;
`endif
  localparam int ENT_W = CMD_W + 2 * VAL_W;
  localparam int SH_W  = NW * WORD_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int IW    = $clog2(NW + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ENT_W-1:0]  r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic              r_rdy_en;
  logic [SH_W-1:0]   r_shift;
  logic [IW-1:0]     r_idx;
  logic [7:0]        r_frame_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_hs;
  logic              w_last;
  logic              w_has_frame;
  logic [ENT_W-1:0]  w_head;
  logic [SH_W-1:0]   w_frame;
`ifdef GCODE_CMD_SER_CHECKSUM_EN
  logic [WORD_W-1:0] w_sum;
`endif

  // in_ready stays low through reset, and for the cycle in which reset is released.
  assign o_in_ready   = r_rdy_en & (r_count != (PW+1)'(DEPTH));
  assign w_push       = i_in_valid & o_in_ready;
  assign w_pop        = (r_state == LOAD);
  assign w_has_frame  = (r_count != '0) & i_ctrl_ready;
  assign o_word_valid = (r_state == SEND);
  assign w_last       = (r_idx == IW'(NW - 1));
  assign w_hs         = o_word_valid & i_word_ready;
  assign o_word_last  = o_word_valid & w_last;
  assign o_word_data  = o_word_valid ? r_shift[WORD_W-1:0] : '0;
  assign o_busy       = (r_state != IDLE) | (r_count != '0);
  assign o_frame_cnt  = r_frame_cnt;
  assign w_head       = r_mem[r_rd_ptr];

  // Lay the FIFO head out as a word-aligned, zero-padded frame (plus checksum when enabled).
  always_comb begin
    w_frame = '0;
    w_frame[CMD_W-1:0] = w_head[ENT_W-1 -: CMD_W];
    w_frame[NC*WORD_W +: VAL_W] = w_head[2*VAL_W-1 -: VAL_W];
    w_frame[(NC+NV)*WORD_W +: VAL_W] = w_head[VAL_W-1:0];
`ifdef GCODE_CMD_SER_CHECKSUM_EN
    w_sum = '0;
    for (int k = 0; k < NW - 1; k++) begin
      w_sum = w_sum ^ w_frame[k*WORD_W +: WORD_W];
    end
    w_frame[(NW-1)*WORD_W +: WORD_W] = w_sum;
`endif
  end

  // FIFO storage needs no reset: the count and pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_cmd, i_x_value, i_y_value};
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic. ctrl_ready is looked at only when deciding whether to start a frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_has_frame) w_next = LOAD;
      LOAD:    w_next = SEND;
      SEND:    if (w_hs && w_last) w_next = w_has_frame ? LOAD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Frame shift register, word index and completed-frame counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_shift <= w_frame;
      r_idx   <= '0;
    end else if (w_hs) begin
      r_shift <= r_shift >> WORD_W;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_gcode_cmd_serializer.sv
// tb_gcode_cmd_serializer
// Directed bench for gcode_cmd_serializer with its default parameters.
// Define GCODE_CMD_SER_CHECKSUM_EN here as well when the DUT is built with the checksum word.
module tb_gcode_cmd_serializer;

`ifdef GCODE_CMD_SER_CHECKSUM_EN
  localparam int NW = 11;
`else
  localparam int NW = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [4:0]  cmd;
  logic [13:0] xValue;
  logic [13:0] yValue;
  logic        ctrlReady;
  logic        wordValid;
  logic        wordReady;
  logic [3:0]  wordData;
  logic        wordLast;
  logic        busy;
  logic [7:0]  frameCnt;

  int nCompared;
  int nMismatched;
  int expCnt;

  gcode_cmd_serializer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_cmd        (cmd),
    .i_x_value    (xValue),
    .i_y_value    (yValue),
    .i_ctrl_ready (ctrlReady),
    .o_word_valid (wordValid),
    .i_word_ready (wordReady),
    .o_word_data  (wordData),
    .o_word_last  (wordLast),
    .o_busy       (busy),
    .o_frame_cnt  (frameCnt)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame word i of a command. The index after the last y word returns the XOR checksum.
  function automatic logic [3:0] expWord(input logic [4:0] c, input logic [13:0] x,
                                         input logic [13:0] y, input int i);
    logic [39:0] v;
    logic [3:0]  s;
    v = {2'b00, y, 2'b00, x, 3'b000, c};
    s = 4'h0;
    for (int k = 0; k < 10; k++) s = s ^ v[k*4 +: 4];
    if (i < 10) return v[i*4 +: 4];
    return s;
  endfunction

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and record the result.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single cycle.
  task automatic applyStimulus(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
    inValid = 1'b1;
    cmd     = c;
    xValue  = x;
    yValue  = y;
    step();
    inValid = 1'b0;
  endtask

  // Check every word of a frame, starting from its first word, with word_ready held at 1.
  task automatic drainFrame(input logic [4:0] c, input logic [13:0] x, input logic [13:0] y);
    for (int i = 0; i < NW; i++) begin
      checkOutput($sformatf("valid_w%0d", i), 32'(wordValid), 32'd1);
      checkOutput($sformatf("data_w%0d", i), 32'(wordData), 32'(expWord(c, x, y, i)));
      checkOutput($sformatf("last_w%0d", i), 32'(wordLast), 32'(i == NW - 1));
      step();
    end
    expCnt++;
  endtask

  logic [3:0]  goldWords [11];
  logic [4:0]  qCmd [4];
  logic [13:0] qX   [4];
  logic [13:0] qY   [4];
  bit          done;

  // Directed test sequence.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expCnt      = 0;
    goldWords   = '{4'h3, 4'h1, 4'hC, 4'h5, 4'hA, 4'h2, 4'hF, 4'h0, 4'hF, 4'h1, 4'h2};
    qCmd = '{5'h01, 5'h02, 5'h03, 5'h04};
    qX   = '{14'h0111, 14'h0222, 14'h0333, 14'h0444};
    qY   = '{14'h1001, 14'h2002, 14'h3003, 14'h3FFF};
    rst_n = 1'b0; inValid = 1'b0; cmd = '0; xValue = '0; yValue = '0;
    ctrlReady = 1'b0; wordReady = 1'b0;

    // Values held during reset.
    #2;
    checkOutput("rst_in_ready", 32'(inReady), 32'd0);
    checkOutput("rst_word_valid", 32'(wordValid), 32'd0);
    checkOutput("rst_word_last", 32'(wordLast), 32'd0);
    checkOutput("rst_word_data", 32'(wordData), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frameCnt), 32'd0);
    step();
    step();
    checkOutput("rst_in_ready_hold", 32'(inReady), 32'd0);
    #2 rst_n = 1'b1;
    step();
    checkOutput("in_ready_after_rst", 32'(inReady), 32'd1);

    // Reference frame and its latency from push to first word.
    ctrlReady = 1'b1; wordReady = 1'b1;
    applyStimulus(5'h13, 14'h2A5C, 14'h1F0F);
    checkOutput("lat_n_valid", 32'(wordValid), 32'd0);
    checkOutput("lat_n_busy", 32'(busy), 32'd1);
    step();
    checkOutput("lat_n1_valid", 32'(wordValid), 32'd0);
    step();
    for (int i = 0; i < NW; i++) begin
      checkOutput($sformatf("ref_valid%0d", i), 32'(wordValid), 32'd1);
      checkOutput($sformatf("ref_data%0d", i), 32'(wordData), 32'(goldWords[i]));
      checkOutput($sformatf("ref_last%0d", i), 32'(wordLast), 32'(i == NW - 1));
      step();
    end
    expCnt++;
    checkOutput("ref_frame_cnt", 32'(frameCnt), 32'd1);
    checkOutput("ref_idle_valid", 32'(wordValid), 32'd0);
    checkOutput("ref_idle_busy", 32'(busy), 32'd0);

    // word_ready toggles every cycle; the presented word must hold across each stall.
    wordReady = 1'b0;
    applyStimulus(5'h0A, 14'h1234, 14'h3ABC);
    step();
    step();
    for (int i = 0; i < NW; i++) begin
      checkOutput($sformatf("stall_a%0d", i), 32'(wordData), 32'(expWord(5'h0A, 14'h1234, 14'h3ABC, i)));
      step();
      checkOutput($sformatf("stall_v%0d", i), 32'(wordValid), 32'd1);
      checkOutput($sformatf("stall_b%0d", i), 32'(wordData), 32'(expWord(5'h0A, 14'h1234, 14'h3ABC, i)));
      checkOutput($sformatf("stall_l%0d", i), 32'(wordLast), 32'(i == NW - 1));
      wordReady = 1'b1;
      step();
      wordReady = 1'b0;
    end
    expCnt++;
    checkOutput("stall_frame_cnt", 32'(frameCnt), 32'(expCnt));

    // Two frames queued back to back: a single LOAD cycle separates them.
    wordReady = 1'b1;
    inValid = 1'b1; cmd = 5'h01; xValue = 14'h0001; yValue = 14'h0002;
    step();
    cmd = 5'h1F; xValue = 14'h3FFF; yValue = 14'h0000;
    step();
    inValid = 1'b0;
    step();
    drainFrame(5'h01, 14'h0001, 14'h0002);
    checkOutput("b2b_load_valid", 32'(wordValid), 32'd0);
    checkOutput("b2b_load_busy", 32'(busy), 32'd1);
    step();
    drainFrame(5'h1F, 14'h3FFF, 14'h0000);
    checkOutput("b2b_frame_cnt", 32'(frameCnt), 32'(expCnt));
    checkOutput("b2b_idle_busy", 32'(busy), 32'd0);

    // Fill the FIFO while the controller is not ready; the fifth command must be held off.
    ctrlReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("fill_ready%0d", k), 32'(inReady), 32'd1);
      applyStimulus(qCmd[k], qX[k], qY[k]);
    end
    checkOutput("full_in_ready", 32'(inReady), 32'd0);
    inValid = 1'b1; cmd = 5'h1E; xValue = 14'h1555; yValue = 14'h2AAA;
    step();
    checkOutput("full_hold_ready", 32'(inReady), 32'd0);
    checkOutput("full_no_valid", 32'(wordValid), 32'd0);
    checkOutput("full_busy", 32'(busy), 32'd1);
    step();
    checkOutput("full_hold_ready2", 32'(inReady), 32'd0);
    checkOutput("full_no_valid2", 32'(wordValid), 32'd0);
    inValid = 1'b0;
    ctrlReady = 1'b1;
    step();
    checkOutput("drain_load_valid", 32'(wordValid), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      drainFrame(qCmd[k], qX[k], qY[k]);
      if (k < 3) begin
        checkOutput($sformatf("drain_gap%0d", k), 32'(wordValid), 32'd0);
        step();
      end
    end
    checkOutput("drain_busy", 32'(busy), 32'd0);
    checkOutput("drain_valid", 32'(wordValid), 32'd0);
    checkOutput("drain_frame_cnt", 32'(frameCnt), 32'(expCnt));

    // Reset asserted while the fourth word of a frame is presented, with a second frame queued.
    inValid = 1'b1; cmd = 5'h15; xValue = 14'h0ABC; yValue = 14'h1357;
    step();
    cmd = 5'h0C; xValue = 14'h2468; yValue = 14'h0F0F;
    step();
    inValid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) step();
    checkOutput("mid_word3", 32'(wordData), 32'(expWord(5'h15, 14'h0ABC, 14'h1357, 3)));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(wordValid), 32'd0);
    checkOutput("mid_rst_last", 32'(wordLast), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cnt", 32'(frameCnt), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(inReady), 32'd0);
    step();
    #2 rst_n = 1'b1;
    expCnt = 0;
    step();
    checkOutput("post_rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("post_rst_valid", 32'(wordValid), 32'd0);
    step();
    step();
    checkOutput("post_rst_valid2", 32'(wordValid), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    applyStimulus(5'h07, 14'h3210, 14'h0123);
    step();
    step();
    drainFrame(5'h07, 14'h3210, 14'h0123);
    checkOutput("post_rst_cnt", 32'(frameCnt), 32'(expCnt));

    // Frame counter wrap: 254 more frames bring it to 255, and one more wraps it to 0.
    for (int f = 0; f < 255; f++) begin
      applyStimulus(5'(f), 14'(f * 3), 14'(f * 7));
      done = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (wordValid && wordLast) begin
          step();
          done = 1'b1;
          break;
        end
        step();
      end
      checkOutput($sformatf("wrap_done%0d", f), 32'(done), 32'd1);
      if (f == 253) checkOutput("wrap_cnt_255", 32'(frameCnt), 32'd255);
    end
    checkOutput("wrap_cnt_0", 32'(frameCnt), 32'd0);
    checkOutput("wrap_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
